id_ex_skid_reg: RTL and testbench

Parametrised ID/EX pipeline stage register for the MIPS pipeline. It holds the decoded control bundle (WB enable, MemRead, MemWrite, branch-taken, ALU op) and the data bundle (PC, operand values, store data, source and destination register numbers) between decode and execute. Unlike a plain register, it adds a valid/ready handshake with a one-entry skid buffer, so a downstream stall never drops an instruction. It also adds a synchronous flush that inserts a bubble, and a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 59 +++++
 rtl/id_ex_skid_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_skid_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: default field widths, ID/EX control and data bundles.
// Used by the ID/EX stage register and anything that builds or consumes its payload.
package pipe_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PC_W   = 10;
    localparam int DEF_REG_W  = 4;
    localparam int DEF_ALU_W  = 3;

    typedef struct packed {
        logic                 wb;
        logic                 memrd;
        logic                 memwr;
        logic                 br;
        logic [DEF_ALU_W-1:0] aluop;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] val1;
        logic [DEF_DATA_W-1:0] val2;
        logic [DEF_DATA_W-1:0] reg2;
        logic [DEF_REG_W-1:0]  src1;
        logic [DEF_REG_W-1:0]  src2;
        logic [DEF_REG_W-1:0]  dst;
    } id_ex_data_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready buffer (main + skid) with synchronous flush of both entries.
// Latency 1 cycle in->out; in_rdy is the registered skid-empty flag, never combinational on out_rdy.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         main_vld;
    logic [W-1:0] main_dat;
    logic         skid_vld;
    logic [W-1:0] skid_dat;
    logic         in_fire;
    logic         out_fire;
    logic         main_load;

    assign in_rdy    = !skid_vld;
    assign out_vld   = main_vld;
    assign out_dat   = main_dat;
    assign in_fire   = in_vld && !skid_vld;
    assign out_fire  = main_vld && out_rdy;
    assign main_load = !main_vld || out_fire;

    // Skid is only ever full while main is full, so draining it first keeps FIFO order.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_load) begin
            if (skid_vld) begin
                main_vld <= 1'b1;
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (in_fire) begin
                main_vld <= 1'b1;
                main_dat <= in_dat;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (in_fire) begin
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX stage register with valid/ready skid buffering, flush-to-bubble and a saturating stall counter.
// Latency 1 cycle; a downstream stall fills the skid entry and then drops in_ready, nothing is lost.
module id_ex_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int ALU_W  = DEF_ALU_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_Enable,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Br_Taken,
    input  logic [ALU_W-1:0]  ALUOperation,
    input  logic [PC_W-1:0]   PC,
    input  logic [DATA_W-1:0] Reg1,
    input  logic [DATA_W-1:0] Reg2,
    input  logic [DATA_W-1:0] RegOrExtend,
    input  logic [REG_W-1:0]  SrcReg1,
    input  logic [REG_W-1:0]  SrcReg2Or0,
    input  logic [REG_W-1:0]  DstReg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WBEnableOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              Br_TakenOut,
    output logic [ALU_W-1:0]  ALUOperationOut,
    output logic [PC_W-1:0]   PCOut,
    output logic [DATA_W-1:0] Val1,
    output logic [DATA_W-1:0] Val2,
    output logic [DATA_W-1:0] Reg2Out,
    output logic [REG_W-1:0]  Src1Out,
    output logic [REG_W-1:0]  Src2Out,
    output logic [REG_W-1:0]  DstRegOut,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic             wb;
        logic             memrd;
        logic             memwr;
        logic             br;
        logic [ALU_W-1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  dst;
    } data_t;

    localparam int PAY_W = $bits(ctrl_t) + $bits(data_t);

    ctrl_t             in_ctrl;
    data_t             in_data;
    ctrl_t             held_ctrl;
    ctrl_t             vis_ctrl;
    data_t             held_data;
    logic [PAY_W-1:0]  out_pay;

    assign in_ctrl = '{wb: WB_Enable, memrd: MemRead, memwr: MemWrite,
                       br: Br_Taken, aluop: ALUOperation};
    assign in_data = '{pc: PC, val1: Reg1, val2: RegOrExtend, reg2: Reg2,
                       src1: SrcReg1, src2: SrcReg2Or0, dst: DstReg};

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_buf (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  ({in_ctrl, in_data}),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (out_pay)
    );

    assign {held_ctrl, held_data} = out_pay;

    // Control is masked from the registered valid so an empty stage always looks like a bubble.
    assign vis_ctrl = out_valid ? held_ctrl : ctrl_t'('0);

    assign WBEnableOut     = vis_ctrl.wb;
    assign MemReadOut      = vis_ctrl.memrd;
    assign MemWriteOut     = vis_ctrl.memwr;
    assign Br_TakenOut     = vis_ctrl.br;
    assign ALUOperationOut = vis_ctrl.aluop;
    assign PCOut           = held_data.pc;
    assign Val1            = held_data.val1;
    assign Val2            = held_data.val2;
    assign Reg2Out         = held_data.reg2;
    assign Src1Out         = held_data.src1;
    assign Src2Out         = held_data.src2;
    assign DstRegOut       = held_data.dst;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed, table-driven check of the ID/EX skid register: streaming, backpressure, flush, counter, reset.
module tb_id_ex_skid_reg;

    logic        Clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        WB_Enable, MemRead, MemWrite, Br_Taken;
    logic [2:0]  ALUOperation;
    logic [9:0]  PC;
    logic [15:0] Reg1, Reg2, RegOrExtend;
    logic [3:0]  SrcReg1, SrcReg2Or0, DstReg;
    logic        flush;
    logic        out_valid, out_ready;
    logic        WBEnableOut, MemReadOut, MemWriteOut, Br_TakenOut;
    logic [2:0]  ALUOperationOut;
    logic [9:0]  PCOut;
    logic [15:0] Val1, Val2, Reg2Out;
    logic [3:0]  Src1Out, Src2Out, DstRegOut;
    logic        cnt_clr;
    logic [3:0]  stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_skid_reg #(
        .DATA_W (16), .PC_W (10), .REG_W (4), .ALU_W (3), .CNT_W (4)
    ) dut (
        .Clk (Clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready),
        .WB_Enable (WB_Enable), .MemRead (MemRead), .MemWrite (MemWrite), .Br_Taken (Br_Taken),
        .ALUOperation (ALUOperation), .PC (PC),
        .Reg1 (Reg1), .Reg2 (Reg2), .RegOrExtend (RegOrExtend),
        .SrcReg1 (SrcReg1), .SrcReg2Or0 (SrcReg2Or0), .DstReg (DstReg),
        .flush (flush),
        .out_valid (out_valid), .out_ready (out_ready),
        .WBEnableOut (WBEnableOut), .MemReadOut (MemReadOut), .MemWriteOut (MemWriteOut),
        .Br_TakenOut (Br_TakenOut), .ALUOperationOut (ALUOperationOut),
        .PCOut (PCOut), .Val1 (Val1), .Val2 (Val2), .Reg2Out (Reg2Out),
        .Src1Out (Src1Out), .Src2Out (Src2Out), .DstRegOut (DstRegOut),
        .cnt_clr (cnt_clr), .stall_cycles (stall_cycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        iv;
        logic [9:0]  pc;
        logic [15:0] r1;
        logic        wb;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        e_ov;
        logic [9:0]  e_pc;
        logic [15:0] e_v1;
        logic        e_wb;
        logic        e_ir;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [9:0] pc, input logic [15:0] r1,
                                input logic wb, input logic ordy, input logic fl, input logic clr,
                                input logic e_ov, input logic [9:0] e_pc, input logic [15:0] e_v1,
                                input logic e_wb, input logic e_ir, input logic [3:0] e_cnt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.r1 = r1; v.wb = wb; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_v1 = e_v1; v.e_wb = e_wb; v.e_ir = e_ir; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Every non-control field is derived from PC and Reg1 so slicing errors show up.
    task automatic drive(input logic [9:0] pc, input logic [15:0] r1, input logic wb);
        PC           = pc;
        Reg1         = r1;
        Reg2         = ~r1;
        RegOrExtend  = r1 + 16'd1;
        SrcReg1      = pc[3:0];
        SrcReg2Or0   = pc[3:0] + 4'd1;
        DstReg       = pc[3:0] + 4'd2;
        WB_Enable    = wb;
        MemRead      = pc[1];
        MemWrite     = pc[2];
        Br_Taken     = pc[0] ^ wb;
        ALUOperation = pc[2:0];
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [9:0] pc,
                             input logic [15:0] v1, input logic wb);
        logic [6:0]  e_ctrl;
        logic [15:0] e_v2, e_r2;
        logic [3:0]  e_s1, e_s2, e_d;
        e_ctrl = ov ? {wb, pc[1], pc[2], pc[0] ^ wb, pc[2:0]} : 7'd0;
        e_v2 = v1 + 16'd1;
        e_r2 = ~v1;
        e_s1 = pc[3:0];
        e_s2 = pc[3:0] + 4'd1;
        e_d  = pc[3:0] + 4'd2;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".ctrl"}, 32'({WBEnableOut, MemReadOut, MemWriteOut, Br_TakenOut, ALUOperationOut}),
            32'(e_ctrl));
        if (ov) begin
            chk({tag, ".PCOut"}, 32'(PCOut), 32'(pc));
            chk({tag, ".Val1"}, 32'(Val1), 32'(v1));
            chk({tag, ".Val2"}, 32'(Val2), 32'(e_v2));
            chk({tag, ".Reg2Out"}, 32'(Reg2Out), 32'(e_r2));
            chk({tag, ".regs"}, 32'({Src1Out, Src2Out, DstRegOut}), 32'({e_s1, e_s2, e_d}));
        end
    endtask

    initial begin
        // Reset with junk on every input.
        rst_n = 1'b0;
        in_valid = 1'($urandom); out_ready = 1'($urandom);
        flush = 1'($urandom); cnt_clr = 1'($urandom);
        drive(10'($urandom), 16'($urandom), 1'($urandom));
        #23;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.stall", 32'(stall_cycles), 0);
        chk("rst.ctrl", 32'({WBEnableOut, MemReadOut, MemWriteOut, Br_TakenOut, ALUOperationOut}), 0);
        chk("rst.data", 32'({PCOut, Val1}), 0);
        chk("rst.data2", 32'({Val2, Reg2Out}), 0);
        chk("rst.regs", 32'({Src1Out, Src2Out, DstRegOut}), 0);
        rst_n = 1'b1;

        //            iv pc     r1        wb ordy fl clr | ov pc    v1        wb ir cnt
        vq.push_back(mk(1, 10'h004, 16'h1234, 1, 1, 0, 0,  1, 10'h004, 16'h1234, 1, 1, 4'd0));
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1, 10'(i), 16'(16'h100 + i), 1'(i & 1), 1, 0, 0,
                            1, 10'(i), 16'(16'h100 + i), 1'(i & 1), 1, 4'd0));
        vq.push_back(mk(0, 10'd0,  16'h0,    0, 1, 0, 0,  0, 10'd0,  16'h0,    0, 1, 4'd0));
        vq.push_back(mk(1, 10'd20, 16'hA014, 1, 0, 0, 0,  1, 10'd20, 16'hA014, 1, 1, 4'd0));
        vq.push_back(mk(1, 10'd21, 16'hA015, 1, 0, 0, 0,  1, 10'd20, 16'hA014, 1, 0, 4'd1));
        vq.push_back(mk(1, 10'd22, 16'hA016, 1, 0, 0, 0,  1, 10'd20, 16'hA014, 1, 0, 4'd2));
        vq.push_back(mk(1, 10'd22, 16'hA016, 1, 0, 0, 0,  1, 10'd20, 16'hA014, 1, 0, 4'd3));
        vq.push_back(mk(1, 10'd22, 16'hA016, 1, 1, 0, 0,  1, 10'd21, 16'hA015, 1, 1, 4'd3));
        vq.push_back(mk(1, 10'd22, 16'hA016, 1, 1, 0, 0,  1, 10'd22, 16'hA016, 1, 1, 4'd3));
        vq.push_back(mk(0, 10'd0,  16'h0,    0, 1, 0, 0,  0, 10'd0,  16'h0,    0, 1, 4'd3));
        // Flush while full, with a third instruction presented.
        vq.push_back(mk(1, 10'd30, 16'hA01E, 1, 0, 0, 1,  1, 10'd30, 16'hA01E, 1, 1, 4'd0));
        vq.push_back(mk(1, 10'd31, 16'hA01F, 1, 0, 0, 0,  1, 10'd30, 16'hA01E, 1, 0, 4'd1));
        vq.push_back(mk(1, 10'd32, 16'hA020, 1, 0, 1, 0,  0, 10'd0,  16'h0,    0, 1, 4'd2));
        vq.push_back(mk(0, 10'd0,  16'h0,    0, 1, 0, 0,  0, 10'd0,  16'h0,    0, 1, 4'd2));
        // Flush coinciding with out_fire and in_fire.
        vq.push_back(mk(1, 10'd40, 16'hA028, 1, 1, 0, 0,  1, 10'd40, 16'hA028, 1, 1, 4'd2));
        vq.push_back(mk(1, 10'd41, 16'hA029, 1, 1, 1, 0,  0, 10'd0,  16'h0,    0, 1, 4'd2));
        vq.push_back(mk(1, 10'd42, 16'hA02A, 1, 1, 0, 0,  1, 10'd42, 16'hA02A, 1, 1, 4'd2));
        vq.push_back(mk(0, 10'd0,  16'h0,    0, 1, 0, 1,  0, 10'd0,  16'h0,    0, 1, 4'd0));

        foreach (vq[i]) begin
            in_valid  = vq[i].iv;
            out_ready = vq[i].ordy;
            flush     = vq[i].fl;
            cnt_clr   = vq[i].clr;
            drive(vq[i].pc, vq[i].r1, vq[i].wb);
            step();
            check_out($sformatf("v%0d", i), vq[i].e_ov, vq[i].e_pc, vq[i].e_v1, vq[i].e_wb);
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
            chk($sformatf("v%0d.stall", i), 32'(stall_cycles), 32'(vq[i].e_cnt));
        end

        // Counter saturation: 20 stalled cycles on a 4-bit counter.
        flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1;
        drive(10'd50, 16'hA032, 1'b1);
        step();
        check_out("sat.load", 1'b1, 10'd50, 16'hA032, 1'b1);
        chk("sat.load.stall", 32'(stall_cycles), 0);
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat.stall", 32'(stall_cycles), 32'hF);
        check_out("sat.hold", 1'b1, 10'd50, 16'hA032, 1'b1);
        cnt_clr = 1'b1;
        step();
        chk("sat.clr", 32'(stall_cycles), 0);
        cnt_clr = 1'b0;
        step();
        chk("sat.resume", 32'(stall_cycles), 1);

        // Fill the skid, then reset asynchronously between edges.
        in_valid = 1'b1;
        drive(10'd51, 16'hA033, 1'b1);
        step();
        chk("full.in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 0);
        chk("arst.in_ready", 32'(in_ready), 1);
        chk("arst.stall", 32'(stall_cycles), 0);
        chk("arst.ctrl", 32'({WBEnableOut, MemReadOut, MemWriteOut, Br_TakenOut, ALUOperationOut}), 0);
        chk("arst.data", 32'({PCOut, Val1}), 0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post.out_valid", 32'(out_valid), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
